// File: rtl/ct_sensor_conditioner.sv
// ============================================================================
//  Module      : ct_sensor_conditioner
//  Description : Turns the raw country-road loop detector into a clean,
//                debounced presence request with hold, stuck-loop fault
//                detection and a saturating vehicle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ct_sensor_conditioner #(
    parameter int DEBOUNCE    = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int STUCK_LIMIT = 1024,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             loop_raw,
    input  logic             clear_fault,
    input  logic             count_clear,
    output logic             ct_sensor,
    output logic             fault,
    output logic [CNT_W-1:0] vehicle_count
);

    localparam int c_DEB_W   = $clog2(DEBOUNCE) + 1;
    localparam int c_HOLD_W  = $clog2(HOLD_CYCLES) + 1;
    localparam int c_STUCK_W = $clog2(STUCK_LIMIT) + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_QUAL_ON  = 3'd1,
        S_PRESENT  = 3'd2,
        S_QUAL_OFF = 3'd3,
        S_HOLD     = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    logic                 r_s1;
    logic                 r_s2;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_DEB_W-1:0]   r_deb_cnt;
    logic [c_DEB_W-1:0]   w_deb_nxt;
    logic [c_HOLD_W-1:0]  r_hold_cnt;
    logic [c_HOLD_W-1:0]  w_hold_nxt;
    logic [c_STUCK_W-1:0] r_stuck_cnt;
    logic [c_STUCK_W-1:0] w_stuck_nxt;
    logic [c_STUCK_W-1:0] w_stuck_inc;
    logic                 w_stuck_hit;
    logic                 w_inc;
    logic [CNT_W-1:0]     r_count;

    // Two-flop synchroniser; only r_s2 feeds the state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= loop_raw;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_deb_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_stuck_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_deb_cnt   <= w_deb_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_stuck_cnt <= w_stuck_nxt;
        end
    end

    assign w_stuck_inc = r_stuck_cnt + 1'b1;
    assign w_stuck_hit = (w_stuck_inc == c_STUCK_W'(STUCK_LIMIT));

    always_comb begin
        w_state_nxt = r_state;
        w_deb_nxt   = r_deb_cnt;
        w_hold_nxt  = r_hold_cnt;
        w_stuck_nxt = r_stuck_cnt;
        w_inc       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_s2) begin
                    w_state_nxt = S_QUAL_ON;
                    w_deb_nxt   = c_DEB_W'(1);
                end
            end
            S_QUAL_ON: begin
                if (!r_s2) begin
                    w_state_nxt = S_IDLE;
                end else if (r_deb_cnt == c_DEB_W'(DEBOUNCE - 1)) begin
                    w_state_nxt = S_PRESENT;
                    w_stuck_nxt = '0;
                    w_inc       = 1'b1;
                end else begin
                    w_deb_nxt = r_deb_cnt + 1'b1;
                end
            end
            S_PRESENT: begin
                w_stuck_nxt = w_stuck_inc;
                if (w_stuck_hit) begin
                    w_state_nxt = S_FAULT;
                end else if (!r_s2) begin
                    w_state_nxt = S_QUAL_OFF;
                    w_deb_nxt   = c_DEB_W'(1);
                end
            end
            S_QUAL_OFF: begin
                // A bounce back high resumes presence without a new count.
                w_stuck_nxt = w_stuck_inc;
                if (w_stuck_hit) begin
                    w_state_nxt = S_FAULT;
                end else if (r_s2) begin
                    w_state_nxt = S_PRESENT;
                end else if (r_deb_cnt == c_DEB_W'(DEBOUNCE - 1)) begin
                    w_state_nxt = S_HOLD;
                    w_hold_nxt  = '0;
                end else begin
                    w_deb_nxt = r_deb_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == c_HOLD_W'(HOLD_CYCLES - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            S_FAULT: begin
                if (clear_fault && !r_s2) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Clear dominates a coincident increment; the counter never wraps.
    always_ff @(posedge clk) begin
        if (reset || count_clear) begin
            r_count <= '0;
        end else if (w_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    always_comb begin
        ct_sensor = 1'b0;
        fault     = 1'b0;
        case (r_state)
            S_PRESENT, S_QUAL_OFF, S_HOLD: ct_sensor = 1'b1;
            S_FAULT: begin
                ct_sensor = 1'b1;
                fault     = 1'b1;
            end
            default: ct_sensor = 1'b0;
        endcase
    end

    assign vehicle_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_ct_sensor_conditioner.sv
// ============================================================================
//  Module      : tb_ct_sensor_conditioner
//  Description : Directed, table-driven bench for ct_sensor_conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ct_sensor_conditioner;

    logic       clk;
    logic       reset;
    logic       loop_raw;
    logic       clear_fault;
    logic       count_clear;
    logic       ct_sensor;
    logic       fault;
    logic [1:0] vehicle_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       raw;
        logic       cf;
        logic       cc;
        logic       rst;
        logic       ct;
        logic       flt;
        logic [1:0] cnt;
        string      name;
    } vec_t;

    vec_t vecs[$];

    ct_sensor_conditioner #(
        .DEBOUNCE   (4),
        .HOLD_CYCLES(8),
        .STUCK_LIMIT(16),
        .CNT_W      (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .loop_raw     (loop_raw),
        .clear_fault  (clear_fault),
        .count_clear  (count_clear),
        .ct_sensor    (ct_sensor),
        .fault        (fault),
        .vehicle_count(vehicle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic raw, input logic cf, input logic cc,
                                input logic rst, input logic ct, input logic flt,
                                input logic [1:0] cnt, input string name);
        vec_t v;
        v.raw = raw; v.cf = cf; v.cc = cc; v.rst = rst;
        v.ct = ct; v.flt = flt; v.cnt = cnt; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic raw, input logic cf, input logic cc, input logic rst);
        @(negedge clk);
        loop_raw    = raw;
        clear_fault = cf;
        count_clear = cc;
        reset       = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic ct, input logic flt,
                             input logic [1:0] cnt);
        check({name, ".ct"},  32'(ct_sensor),     32'(ct));
        check({name, ".flt"}, 32'(fault),         32'(flt));
        check({name, ".cnt"}, 32'(vehicle_count), 32'(cnt));
    endtask

    // One full vehicle: arrival, optional clear on the qualifying edge, departure.
    task automatic vehicle(input logic cc_at_qual, input logic [1:0] exp_cnt, input string name);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b0, (i == 6) ? cc_at_qual : 1'b0, 1'b0);
            if (i == 5) check({name, ".pre"}, 32'(ct_sensor), 32'd0);
        end
        check_all({name, ".qual"}, 1'b1, 1'b0, exp_cnt);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check({name, ".gone"}, 32'(ct_sensor), 32'd0);
    endtask

    initial begin
        reset = 1'b1; loop_raw = 1'b0; clear_fault = 1'b0; count_clear = 1'b0;

        add(0, 0, 0, 1, 0, 0, 0, "reset0");
        add(0, 0, 0, 1, 0, 0, 0, "reset1");
        for (int i = 1; i <= 5; i++) add(1, 0, 0, 0, 0, 0, 0, "arrive_wait");
        add(1, 0, 0, 0, 1, 0, 1, "arrive_qual");
        // Departure with a two-sample bounce high mid-fall.
        add(0, 0, 0, 0, 1, 0, 1, "depart");
        add(0, 0, 0, 0, 1, 0, 1, "depart");
        add(1, 0, 0, 0, 1, 0, 1, "bounce");
        add(1, 0, 0, 0, 1, 0, 1, "bounce");
        for (int i = 0; i < 13; i++) add(0, 0, 0, 0, 1, 0, 1, "offhold");
        add(0, 0, 0, 0, 0, 0, 1, "hold_end");
        // Glitches of 1, 2 and 3 samples with 3 low samples between.
        add(1, 0, 0, 0, 0, 0, 1, "glitch1");
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 1, "gap");
        for (int i = 0; i < 2; i++) add(1, 0, 0, 0, 0, 0, 1, "glitch2");
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 1, "gap");
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 1, "glitch3");
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 1, "gap");

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].raw, vecs[i].cf, vecs[i].cc, vecs[i].rst);
            check_all($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].ct, vecs[i].flt, vecs[i].cnt);
        end

        // Saturating counter: vehicles 2..5, then clear coinciding with the 6th.
        vehicle(1'b0, 2'd2, "veh2");
        vehicle(1'b0, 2'd3, "veh3");
        vehicle(1'b0, 2'd3, "veh4");
        vehicle(1'b0, 2'd3, "veh5");
        vehicle(1'b1, 2'd0, "veh6_clr");

        // Stuck loop: 16 cycles of presence after qualification raise fault.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("stuck_qual", 1'b1, 1'b0, 2'd1);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("stuck_pre", 32'(fault), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("stuck_hit", 1'b1, 1'b1, 2'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("clr_ignored", 1'b1, 1'b1, 2'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("fault_wait", 32'(fault), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_all("clr_ok", 1'b0, 1'b0, 2'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_all("idle_after", 1'b0, 1'b0, 2'd1);

        // Reset while PRESENT.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("pres_before_rst", 1'b1, 1'b0, 2'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_all("rst_in_present", 1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while FAULT.
        for (int i = 0; i < 22; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("fault_before_rst", 1'b1, 1'b1, 2'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_all("rst_in_fault", 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check_all("idle_after_rst", 1'b0, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
